// File: rtl/xm_alu_pc_addr_unit_if.sv
// Datapath bundle between the X-Makina control/register file and the execute/address unit.
// The master side drives operands and strobes; the slave side returns ALU, PC and decode results.
interface xm_alu_pc_addr_unit_if #(
    parameter int WORD = 16
);
    logic            pc_wr_i;
    logic            pc_sel_i;
    logic [WORD-1:0] branch_offs_i;
    logic            flags_wr_i;
    logic [3:0]      flags_en_i;
    logic [3:0]      alu_op_i;
    logic            bcd_i;
    logic            byte_op_i;
    logic [WORD-1:0] alu_a_i;
    logic [WORD-1:0] alu_b_i;
    logic [1:0]      addr_sel_i;

    logic [WORD-1:0] alu_res_o;
    logic [3:0]      alu_flags_o;
    logic [3:0]      flags_o;
    logic [WORD-1:0] pc_o;
    logic [WORD-1:0] pc_new_o;
    logic            bad_mem_o;
    logic            psw_addr_o;
    logic [1:0]      dat_sel_o;
    logic [WORD-2:0] mar_o;

    modport master (
        output pc_wr_i, pc_sel_i, branch_offs_i, flags_wr_i, flags_en_i,
               alu_op_i, bcd_i, byte_op_i, alu_a_i, alu_b_i, addr_sel_i,
        input  alu_res_o, alu_flags_o, flags_o, pc_o, pc_new_o,
               bad_mem_o, psw_addr_o, dat_sel_o, mar_o
    );

    modport slave (
        input  pc_wr_i, pc_sel_i, branch_offs_i, flags_wr_i, flags_en_i,
               alu_op_i, bcd_i, byte_op_i, alu_a_i, alu_b_i, addr_sel_i,
        output alu_res_o, alu_flags_o, flags_o, pc_o, pc_new_o,
               bad_mem_o, psw_addr_o, dat_sel_o, mar_o
    );
endinterface

// File: rtl/xm_alu_pc_addr_unit.sv
// X-Makina execute/address unit: word/byte ALU, PC with next-PC select, memory address decoder.
// Optional decimal ADD/ADDC is compiled in when XM_BCD_EN is defined.
module xm_alu_pc_addr_unit #(
    parameter int              WORD     = 16,
    parameter logic [WORD-1:0] PSW_ADDR = WORD'(16'hFFFC)
) (
    input  logic                   clk_i,
    input  logic                   arst_i,
    xm_alu_pc_addr_unit_if.slave   bus
);
    localparam int MW  = $clog2(WORD);
    localparam int H   = WORD / 2;
    localparam int WP1 = WORD + 1;

    typedef enum logic [3:0] {
        OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_XOR, OP_AND, OP_OR, OP_BIC,
        OP_MOV, OP_SRA, OP_RRC, OP_SWPB, OP_SXT, OP_CMP, OP_NOT, OP_PASS
    } alu_op_e;

    logic [WORD-1:0] pc_q, pc_d, pc_new;
    logic [3:0]      flags_q, flags_d;

    alu_op_e         op;
    logic            byte_op, cin, cin_eff, sub_op, arith, carry, ovf;
    logic [MW-1:0]   msb;
    logic [WORD-1:0] mask, a_m, b_m, add_b, res, flag_res;
    logic [WORD:0]   sum;
    logic [3:0]      alu_flags;
`ifdef XM_BCD_EN
    logic [WORD-1:0] bcd_res;
    logic            bcd_c;
    logic [4:0]      nib;
`endif

    assign op      = alu_op_e'(bus.alu_op_i);
    assign byte_op = bus.byte_op_i;
    assign cin     = flags_q[0];

    always_comb begin
        mask    = byte_op ? WORD'(8'hFF) : {WORD{1'b1}};
        msb     = byte_op ? MW'(7) : MW'(WORD - 1);
        a_m     = bus.alu_a_i & mask;
        b_m     = bus.alu_b_i & mask;
        sub_op  = (op == OP_SUB) || (op == OP_SUBC) || (op == OP_CMP);
        arith   = sub_op || (op == OP_ADD) || (op == OP_ADDC);
        case (op)
            OP_ADDC, OP_SUBC: cin_eff = cin;
            OP_SUB, OP_CMP:   cin_eff = 1'b1;
            default:          cin_eff = 1'b0;
        endcase
        add_b   = sub_op ? (~bus.alu_b_i & mask) : b_m;
        sum     = {1'b0, a_m} + {1'b0, add_b} + WP1'(cin_eff);
        carry   = byte_op ? sum[8] : sum[WORD];
        ovf     = (a_m[msb] == add_b[msb]) && (sum[msb] != a_m[msb]);

        res = '0;
        case (op)
            OP_ADD, OP_ADDC, OP_SUB, OP_SUBC: res = sum[WORD-1:0];
            OP_XOR:  res = a_m ^ b_m;
            OP_AND:  res = a_m & b_m;
            OP_OR:   res = a_m | b_m;
            OP_BIC:  res = a_m & ~b_m;
            OP_MOV:  res = b_m;
            OP_SRA: begin
                res      = a_m >> 1;
                res[msb] = a_m[msb];
            end
            OP_RRC: begin
                res      = a_m >> 1;
                res[msb] = cin;
            end
            OP_SWPB: res = byte_op ? {{(WORD-8){1'b0}}, a_m[3:0], a_m[7:4]}
                                   : {a_m[H-1:0], a_m[WORD-1:H]};
            OP_SXT:  res = byte_op ? {{(WORD-8){1'b0}}, {4{a_m[3]}}, a_m[3:0]}
                                   : {{H{a_m[H-1]}}, a_m[H-1:0]};
            OP_CMP:  res = a_m;
            OP_NOT:  res = ~a_m;
            OP_PASS: res = a_m;
            default: res = '0;
        endcase
        res = res & mask;
        // CMP reports the subtraction flags while passing the operand through
        flag_res = (op == OP_CMP) ? (sum[WORD-1:0] & mask) : res;

`ifdef XM_BCD_EN
        bcd_c   = (op == OP_ADDC) ? cin : 1'b0;
        bcd_res = '0;
        nib     = '0;
        for (int i = 0; i < WORD / 4; i++) begin
            if (!byte_op || i < 2) begin
                nib = {1'b0, a_m[i*4 +: 4]} + {1'b0, b_m[i*4 +: 4]} + {4'b0, bcd_c};
                if (nib > 5'd9) begin
                    nib   = nib + 5'd6;
                    bcd_c = 1'b1;
                end else begin
                    bcd_c = 1'b0;
                end
                bcd_res[i*4 +: 4] = nib[3:0];
            end
        end
        if (bus.bcd_i && (op == OP_ADD || op == OP_ADDC)) begin
            res      = bcd_res;
            flag_res = bcd_res;
            carry    = bcd_c;
            ovf      = 1'b0;
        end
`endif

        alu_flags[3] = arith ? ovf : 1'b0;
        alu_flags[2] = flag_res[msb];
        alu_flags[1] = (flag_res == '0);
        if (arith)
            alu_flags[0] = carry;
        else if (op == OP_SRA || op == OP_RRC)
            alu_flags[0] = a_m[0];
        else
            alu_flags[0] = 1'b0;
    end

    // Next-PC and flag register update
    always_comb begin
        pc_new = bus.pc_sel_i ? (pc_q + bus.branch_offs_i) : (pc_q + WORD'(2));
        pc_d   = bus.pc_wr_i ? pc_new : pc_q;
        for (int i = 0; i < 4; i++)
            flags_d[i] = (bus.flags_wr_i && bus.flags_en_i[i]) ? alu_flags[i] : flags_q[i];
    end

    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            pc_q    <= '0;
            flags_q <= '0;
        end else begin
            pc_q    <= pc_d;
            flags_q <= flags_d;
        end
    end

    logic [WORD-1:0] addr;

    always_comb begin
        case (bus.addr_sel_i)
            2'd0:    addr = pc_q;
            2'd1:    addr = bus.alu_a_i;
            2'd2:    addr = res;
            default: addr = '0;
        endcase
    end

    assign bus.alu_res_o   = res;
    assign bus.alu_flags_o = alu_flags;
    assign bus.flags_o     = flags_q;
    assign bus.pc_o        = pc_q;
    assign bus.pc_new_o    = pc_new;
    assign bus.bad_mem_o   = !byte_op && addr[0];
    assign bus.psw_addr_o  = (addr == PSW_ADDR);
    assign bus.dat_sel_o   = byte_op ? (addr[0] ? 2'b10 : 2'b01) : 2'b11;
    assign bus.mar_o       = addr[WORD-1:1];
endmodule

// File: tb/tb_xm_alu_pc_addr_unit.sv
// Directed bench for xm_alu_pc_addr_unit: ALU vector table, PC/flag sequences, decoder and async reset.
// Decimal-add expectations follow XM_BCD_EN the same way the design does.
module tb_xm_alu_pc_addr_unit;
    logic clk = 1'b0;
    logic arst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    xm_alu_pc_addr_unit_if #(.WORD(16)) bus ();

    xm_alu_pc_addr_unit #(.WORD(16), .PSW_ADDR(16'hFFFC)) dut (
        .clk_i  (clk),
        .arst_i (arst_n),
        .bus    (bus)
    );

    typedef struct {
        logic [3:0]  op;
        logic        byte_op;
        logic        bcd;
        logic        cin;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [3:0]  flg;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs[NV];

`ifdef XM_BCD_EN
    localparam logic [15:0] BCD1_RES = 16'h0047;
    localparam logic [3:0]  BCD1_FLG = 4'b0000;
    localparam logic [15:0] BCD2_RES = 16'h0000;
    localparam logic [3:0]  BCD2_FLG = 4'b0011;
`else
    localparam logic [15:0] BCD1_RES = 16'h0041;
    localparam logic [3:0]  BCD1_FLG = 4'b0000;
    localparam logic [15:0] BCD2_RES = 16'h999A;
    localparam logic [3:0]  BCD2_FLG = 4'b0100;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.pc_wr_i       = 1'b0;
        bus.pc_sel_i      = 1'b0;
        bus.branch_offs_i = 16'h0000;
        bus.flags_wr_i    = 1'b0;
        bus.flags_en_i    = 4'b0000;
        bus.alu_op_i      = 4'd0;
        bus.bcd_i         = 1'b0;
        bus.byte_op_i     = 1'b0;
        bus.alu_a_i       = 16'h0000;
        bus.alu_b_i       = 16'h0000;
        bus.addr_sel_i    = 2'd0;
    endtask

    // Loads the carry flag through the ALU: byte ADD FF+01 gives C=1, MOV gives C=0
    task automatic set_cin(input logic c);
        @(negedge clk);
        bus.byte_op_i  = c;
        bus.bcd_i      = 1'b0;
        bus.alu_op_i   = c ? 4'd0 : 4'd8;
        bus.alu_a_i    = 16'h00FF;
        bus.alu_b_i    = 16'h0001;
        bus.flags_wr_i = 1'b1;
        bus.flags_en_i = 4'b0001;
        @(posedge clk);
        #1;
        bus.flags_wr_i = 1'b0;
        check("cin_load", {31'd0, bus.flags_o[0]}, {31'd0, c});
    endtask

    task automatic pc_step(input logic sel, input logic [15:0] offs, input logic [15:0] exp);
        @(negedge clk);
        bus.pc_sel_i      = sel;
        bus.branch_offs_i = offs;
        bus.pc_wr_i       = 1'b1;
        #1;
        check("pc_new", {16'd0, bus.pc_new_o}, {16'd0, exp});
        @(posedge clk);
        #1;
        bus.pc_wr_i = 1'b0;
        check("pc_load", {16'd0, bus.pc_o}, {16'd0, exp});
        $display("pc step sel=%0d offs=%h -> pc=%h", sel, offs, bus.pc_o);
    endtask

    task automatic dec_check(input string name, input logic [1:0] sel, input logic byte_op,
                             input logic [15:0] a, input logic bad, input logic psw,
                             input logic [1:0] lane, input logic [14:0] mar);
        @(negedge clk);
        bus.addr_sel_i = sel;
        bus.byte_op_i  = byte_op;
        bus.alu_a_i    = a;
        #1;
        check({name, "_bad"}, {31'd0, bus.bad_mem_o}, {31'd0, bad});
        check({name, "_psw"}, {31'd0, bus.psw_addr_o}, {31'd0, psw});
        check({name, "_lane"}, {30'd0, bus.dat_sel_o}, {30'd0, lane});
        check({name, "_mar"}, {17'd0, bus.mar_o}, {17'd0, mar});
        $display("decode %s: bad=%0d psw=%0d sel=%b mar=%h", name, bus.bad_mem_o,
                 bus.psw_addr_o, bus.dat_sel_o, bus.mar_o);
    endtask

    initial begin
        //            op     byte  bcd   cin   a         b         res       flags VNZC
        vecs[0]  = '{4'd0,  1'b0, 1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 4'b1100};
        vecs[1]  = '{4'd0,  1'b1, 1'b0, 1'b0, 16'h00FF, 16'h0001, 16'h0000, 4'b0011};
        vecs[2]  = '{4'd2,  1'b0, 1'b0, 1'b0, 16'h0005, 16'h0005, 16'h0000, 4'b0011};
        vecs[3]  = '{4'd10, 1'b0, 1'b0, 1'b1, 16'h0001, 16'h0000, 16'h8000, 4'b0101};
        vecs[4]  = '{4'd1,  1'b0, 1'b0, 1'b1, 16'h0001, 16'h0001, 16'h0003, 4'b0000};
        vecs[5]  = '{4'd2,  1'b0, 1'b0, 1'b0, 16'h0003, 16'h0005, 16'hFFFE, 4'b0100};
        vecs[6]  = '{4'd3,  1'b0, 1'b0, 1'b0, 16'h0005, 16'h0003, 16'h0001, 4'b0001};
        vecs[7]  = '{4'd4,  1'b0, 1'b0, 1'b0, 16'hF0F0, 16'hFF00, 16'h0FF0, 4'b0000};
        vecs[8]  = '{4'd5,  1'b0, 1'b0, 1'b0, 16'hF0F0, 16'hFF00, 16'hF000, 4'b0100};
        vecs[9]  = '{4'd6,  1'b0, 1'b0, 1'b0, 16'h00F0, 16'h0F00, 16'h0FF0, 4'b0000};
        vecs[10] = '{4'd7,  1'b0, 1'b0, 1'b0, 16'hF0F0, 16'hFF00, 16'h00F0, 4'b0000};
        vecs[11] = '{4'd8,  1'b0, 1'b0, 1'b0, 16'hAAAA, 16'h1234, 16'h1234, 4'b0000};
        vecs[12] = '{4'd9,  1'b0, 1'b0, 1'b0, 16'h8003, 16'h0000, 16'hC001, 4'b0101};
        vecs[13] = '{4'd11, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000, 16'h3412, 4'b0000};
        vecs[14] = '{4'd12, 1'b0, 1'b0, 1'b0, 16'h0080, 16'h0000, 16'hFF80, 4'b0100};
        vecs[15] = '{4'd13, 1'b0, 1'b0, 1'b0, 16'h0005, 16'h0007, 16'h0005, 4'b0100};
        vecs[16] = '{4'd14, 1'b0, 1'b0, 1'b0, 16'h00FF, 16'h0000, 16'hFF00, 4'b0100};
        vecs[17] = '{4'd15, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 16'h0000, 4'b0010};
        vecs[18] = '{4'd2,  1'b1, 1'b0, 1'b0, 16'h0080, 16'h0001, 16'h007F, 4'b1001};
        vecs[19] = '{4'd8,  1'b1, 1'b0, 1'b0, 16'h0000, 16'hABCD, 16'h00CD, 4'b0100};
        vecs[20] = '{4'd11, 1'b1, 1'b0, 1'b0, 16'h12A5, 16'h0000, 16'h005A, 4'b0000};
        vecs[21] = '{4'd12, 1'b1, 1'b0, 1'b0, 16'h000C, 16'h0000, 16'h00FC, 4'b0100};
        vecs[22] = '{4'd10, 1'b1, 1'b0, 1'b0, 16'h0002, 16'h0000, 16'h0001, 4'b0000};
        vecs[23] = '{4'd0,  1'b0, 1'b1, 1'b0, 16'h0019, 16'h0028, BCD1_RES, BCD1_FLG};
        vecs[24] = '{4'd0,  1'b0, 1'b1, 1'b0, 16'h9999, 16'h0001, BCD2_RES, BCD2_FLG};

        idle_inputs();
        #2;
        check("reset_pc", {16'd0, bus.pc_o}, 32'd0);
        check("reset_flags", {28'd0, bus.flags_o}, 32'd0);
        #10;
        arst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            set_cin(vecs[i].cin);
            @(negedge clk);
            bus.alu_op_i  = vecs[i].op;
            bus.byte_op_i = vecs[i].byte_op;
            bus.bcd_i     = vecs[i].bcd;
            bus.alu_a_i   = vecs[i].a;
            bus.alu_b_i   = vecs[i].b;
            #1;
            check($sformatf("vec%0d_res", i), {16'd0, bus.alu_res_o}, {16'd0, vecs[i].res});
            check($sformatf("vec%0d_flags", i), {28'd0, bus.alu_flags_o}, {28'd0, vecs[i].flg});
            $display("vec %0d op=%0d byte=%0d a=%h b=%h -> res=%h flags=%b", i, vecs[i].op,
                     vecs[i].byte_op, vecs[i].a, vecs[i].b, bus.alu_res_o, bus.alu_flags_o);
        end
        idle_inputs();

        // PC sequence including wrap past 0xFFFF
        pc_step(1'b1, 16'h0100, 16'h0100);
        pc_step(1'b0, 16'h0000, 16'h0102);
        pc_step(1'b1, 16'hFFFC, 16'h00FE);
        @(negedge clk);
        @(negedge clk);
        check("pc_hold", {16'd0, bus.pc_o}, 32'h0000_00FE);
        pc_step(1'b1, 16'hFF00, 16'hFFFE);
        pc_step(1'b0, 16'h0000, 16'h0000);

        // Clear all flags, then masked write together with a PC update
        @(negedge clk);
        bus.alu_op_i   = 4'd8;
        bus.alu_b_i    = 16'h0001;
        bus.flags_en_i = 4'b1111;
        bus.flags_wr_i = 1'b1;
        @(posedge clk);
        #1;
        check("flags_clear", {28'd0, bus.flags_o}, 32'd0);
        @(negedge clk);
        bus.alu_op_i   = 4'd0;
        bus.alu_a_i    = 16'h7FFF;
        bus.alu_b_i    = 16'h0001;
        bus.flags_en_i = 4'b1010;
        bus.pc_sel_i   = 1'b0;
        bus.pc_wr_i    = 1'b1;
        @(posedge clk);
        #1;
        bus.flags_wr_i = 1'b0;
        bus.pc_wr_i    = 1'b0;
        check("flags_masked", {28'd0, bus.flags_o}, 32'b1000);
        check("pc_with_flags", {16'd0, bus.pc_o}, 32'h0000_0002);
        $display("masked flag write: flags=%b pc=%h", bus.flags_o, bus.pc_o);
        @(negedge clk);
        bus.alu_op_i = 4'd15;
        bus.alu_a_i  = 16'h0000;
        @(posedge clk);
        #1;
        check("flags_hold", {28'd0, bus.flags_o}, 32'b1000);
        idle_inputs();

        // Decoder: sel, byte, addr(a) -> bad, psw, lane, mar
        dec_check("w1001", 2'd1, 1'b0, 16'h1001, 1'b1, 1'b0, 2'b11, 15'h0800);
        dec_check("b1001", 2'd1, 1'b1, 16'h1001, 1'b0, 1'b0, 2'b10, 15'h0800);
        dec_check("b1000", 2'd1, 1'b1, 16'h1000, 1'b0, 1'b0, 2'b01, 15'h0800);
        dec_check("wFFFC", 2'd1, 1'b0, 16'hFFFC, 1'b0, 1'b1, 2'b11, 15'h7FFE);
        dec_check("bFFFD", 2'd1, 1'b1, 16'hFFFD, 1'b0, 1'b0, 2'b10, 15'h7FFE);
        dec_check("pc",    2'd0, 1'b0, 16'hFFFC, 1'b0, 1'b0, 2'b11, 15'h0001);
        dec_check("zero",  2'd3, 1'b0, 16'hFFFD, 1'b0, 1'b0, 2'b11, 15'h0000);
        @(negedge clk);
        bus.alu_op_i = 4'd8;
        bus.alu_b_i  = 16'hFFFC;
        dec_check("res", 2'd2, 1'b0, 16'h0003, 1'b0, 1'b1, 2'b11, 15'h7FFE);
        idle_inputs();

        // Asynchronous reset between clock edges
        @(negedge clk);
        #2;
        arst_n = 1'b0;
        #1;
        check("async_pc", {16'd0, bus.pc_o}, 32'd0);
        check("async_flags", {28'd0, bus.flags_o}, 32'd0);
        $display("async reset: pc=%h flags=%b", bus.pc_o, bus.flags_o);
        #10;
        arst_n = 1'b1;
        #10;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
